// File: rtl/bip_control_unit.sv
// BIP control unit: run/halt sequencing, registered instruction decode,
// illegal-opcode flag and a saturating retired-instruction counter.
//
// state  | meaning
// IDLE   | after reset, waits for i_start, instructions ignored
// RUN    | decodes one valid instruction per cycle, HALT leaves
// HALTED | stopped by HALT, i_start restarts and clears count/illegal
module bip_control_unit #(
  parameter int N_OP  = 5,
  parameter int TAM   = 2,
  parameter int OP_W  = 3,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_valid,
  input  logic [N_OP-1:0]  i_OPcode,
  output logic [TAM-1:0]   o_selA,
  output logic             o_selB,
  output logic             o_WrAcc,
  output logic [OP_W-1:0]  o_OP,
  output logic             o_WrPC,
  output logic             o_WrRam,
  output logic             o_RdRam,
  output logic             o_busy,
  output logic             o_halted,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_instr_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  localparam logic [N_OP-1:0] OP_HALT  = N_OP'(0);
  localparam logic [N_OP-1:0] OP_STORE = N_OP'(1);
  localparam logic [N_OP-1:0] OP_LOAD  = N_OP'(2);
  localparam logic [N_OP-1:0] OP_LOADI = N_OP'(3);
  localparam logic [N_OP-1:0] OP_ADD   = N_OP'(4);
  localparam logic [N_OP-1:0] OP_ADDI  = N_OP'(5);
  localparam logic [N_OP-1:0] OP_SUB   = N_OP'(6);
  localparam logic [N_OP-1:0] OP_SUBI  = N_OP'(7);
  localparam logic [N_OP-1:0] OP_AND   = N_OP'(8);
  localparam logic [N_OP-1:0] OP_ANDI  = N_OP'(9);
  localparam logic [N_OP-1:0] OP_OR    = N_OP'(10);
  localparam logic [N_OP-1:0] OP_ORI   = N_OP'(11);
  localparam logic [N_OP-1:0] OP_XOR   = N_OP'(12);
  localparam logic [N_OP-1:0] OP_XORI  = N_OP'(13);

  localparam logic [TAM-1:0] SEL_RAM = TAM'(0);
  localparam logic [TAM-1:0] SEL_IMM = TAM'(1);
  localparam logic [TAM-1:0] SEL_ALU = TAM'(2);

  localparam logic [OP_W-1:0] ALU_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] ALU_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] ALU_AND = OP_W'(2);
  localparam logic [OP_W-1:0] ALU_OR  = OP_W'(3);
  localparam logic [OP_W-1:0] ALU_XOR = OP_W'(4);

  state_t            state;
  logic [TAM-1:0]    dSelA;
  logic              dSelB;
  logic              dWrAcc;
  logic [OP_W-1:0]   dOP;
  logic              dWrPC;
  logic              dWrRam;
  logic              dRdRam;
  logic              dIllegal;

  // Unknown opcodes fall through to the default and execute as a PC-only NOP.
  always_comb begin
    dSelA    = SEL_RAM;
    dSelB    = 1'b0;
    dWrAcc   = 1'b0;
    dOP      = ALU_ADD;
    dWrPC    = 1'b1;
    dWrRam   = 1'b0;
    dRdRam   = 1'b0;
    dIllegal = 1'b0;
    case (i_OPcode)
      OP_HALT:  dWrPC = 1'b0;
      OP_STORE: dWrRam = 1'b1;
      OP_LOAD: begin
        dWrAcc = 1'b1;
        dRdRam = 1'b1;
      end
      OP_LOADI: begin
        dSelA  = SEL_IMM;
        dWrAcc = 1'b1;
      end
      OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_AND, OP_ANDI,
      OP_OR, OP_ORI, OP_XOR, OP_XORI: begin
        dSelA  = SEL_ALU;
        dWrAcc = 1'b1;
        dSelB  = i_OPcode[0];
        dRdRam = !i_OPcode[0];
        case (i_OPcode)
          OP_SUB, OP_SUBI: dOP = ALU_SUB;
          OP_AND, OP_ANDI: dOP = ALU_AND;
          OP_OR,  OP_ORI:  dOP = ALU_OR;
          OP_XOR, OP_XORI: dOP = ALU_XOR;
          default:         dOP = ALU_ADD;
        endcase
      end
      default: dIllegal = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state         <= IDLE;
      o_selA        <= '0;
      o_selB        <= 1'b0;
      o_WrAcc       <= 1'b0;
      o_OP          <= '0;
      o_WrPC        <= 1'b0;
      o_WrRam       <= 1'b0;
      o_RdRam       <= 1'b0;
      o_busy        <= 1'b0;
      o_halted      <= 1'b0;
      o_illegal     <= 1'b0;
      o_instr_count <= '0;
    end else begin
      o_selA  <= '0;
      o_selB  <= 1'b0;
      o_WrAcc <= 1'b0;
      o_OP    <= '0;
      o_WrPC  <= 1'b0;
      o_WrRam <= 1'b0;
      o_RdRam <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state  <= RUN;
            o_busy <= 1'b1;
          end
        end
        RUN: begin
          if (i_valid) begin
            if (i_OPcode == OP_HALT) begin
              state    <= HALTED;
              o_busy   <= 1'b0;
              o_halted <= 1'b1;
            end else begin
              o_selA  <= dSelA;
              o_selB  <= dSelB;
              o_WrAcc <= dWrAcc;
              o_OP    <= dOP;
              o_WrPC  <= dWrPC;
              o_WrRam <= dWrRam;
              o_RdRam <= dRdRam;
              if (dIllegal) o_illegal <= 1'b1;
              if (o_instr_count != '1) o_instr_count <= o_instr_count + CNT_W'(1);
            end
          end
        end
        HALTED: begin
          if (i_start) begin
            state         <= RUN;
            o_busy        <= 1'b1;
            o_halted      <= 1'b0;
            o_illegal     <= 1'b0;
            o_instr_count <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
